// File: rtl/tdp_ram_arbiter.sv
// Round-robin arbiter sharing one true dual-port RAM among n_req requesters.
// Up to two grants per cycle (port A, port B); read data is routed back by a per-port tag pipe.
module tdp_ram_arbiter #(
  parameter int n_req   = 4,
  parameter int data_wd = 48,
  parameter int add_wd  = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req,
  input  logic [n_req-1:0]         rnw,
  input  logic [n_req*add_wd-1:0]  add,
  input  logic [n_req*data_wd-1:0] wdata,
  output logic [n_req-1:0]         gnt,
  output logic [n_req-1:0]         rd_valid,
  output logic [n_req*data_wd-1:0] rd_data,
  output logic                     ram_cs_a,
  output logic                     ram_cs_b,
  output logic                     ram_rnw_a,
  output logic                     ram_rnw_b,
  output logic [add_wd-1:0]        ram_a_add,
  output logic [add_wd-1:0]        ram_b_add,
  output logic [data_wd-1:0]       ram_a_din,
  output logic [data_wd-1:0]       ram_b_din,
  input  logic [data_wd-1:0]       ram_a_dout,
  input  logic [data_wd-1:0]       ram_b_dout
);
  localparam int iw = $clog2(n_req);
  typedef logic [iw-1:0] idx_t;
  typedef struct packed { logic vld; logic rd; idx_t own; } tag_t;

  logic [add_wd-1:0]  add_v [n_req];
  logic [data_wd-1:0] wd_v  [n_req];
  logic [data_wd-1:0] hold  [n_req];
  logic [data_wd-1:0] slot  [n_req];
  idx_t               ptr, a_idx, b_idx, scan_j;
  logic               a_vld, b_vld;
  logic [n_req-1:0]   rv_nxt;
  tag_t               tag_a1, tag_a2, tag_b1, tag_b2;

  function automatic idx_t nxt(input idx_t i);
    return (int'(i) == n_req - 1) ? '0 : i + idx_t'(1);
  endfunction

  // A slot takes fresh RAM data in the cycle its read returns, otherwise replays its last value.
  for (genvar i = 0; i < n_req; i++) begin : g_lane
    assign add_v[i] = add[i*add_wd +: add_wd];
    assign wd_v[i]  = wdata[i*data_wd +: data_wd];
    assign slot[i]  = (tag_a2.vld && tag_a2.rd && tag_a2.own == idx_t'(i)) ? ram_a_dout :
                      (tag_b2.vld && tag_b2.rd && tag_b2.own == idx_t'(i)) ? ram_b_dout : hold[i];
    assign rd_data[i*data_wd +: data_wd] = slot[i];
  end

  // Scan from ptr; B skips requesters whose address collides with A unless both are reads.
  always_comb begin
    a_vld  = 1'b0;
    b_vld  = 1'b0;
    a_idx  = '0;
    b_idx  = '0;
    scan_j = '0;
    for (int k = 0; k < n_req; k++) begin
      scan_j = idx_t'((int'(ptr) + k) % n_req);
      if (req[scan_j] && !rst) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = scan_j;
        end else if (!b_vld && (add_v[scan_j] != add_v[a_idx] || (rnw[scan_j] && rnw[a_idx]))) begin
          b_vld = 1'b1;
          b_idx = scan_j;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (a_vld) gnt[a_idx] = 1'b1;
    if (b_vld) gnt[b_idx] = 1'b1;
  end

  always_comb begin
    rv_nxt = '0;
    if (tag_a1.vld && tag_a1.rd) rv_nxt[tag_a1.own] = 1'b1;
    if (tag_b1.vld && tag_b1.rd) rv_nxt[tag_b1.own] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      ram_cs_a  <= 1'b0;
      ram_cs_b  <= 1'b0;
      ram_rnw_a <= 1'b0;
      ram_rnw_b <= 1'b0;
      ram_a_add <= '0;
      ram_b_add <= '0;
      ram_a_din <= '0;
      ram_b_din <= '0;
      tag_a1    <= '0;
      tag_a2    <= '0;
      tag_b1    <= '0;
      tag_b2    <= '0;
      rd_valid  <= '0;
      for (int i = 0; i < n_req; i++) hold[i] <= '0;
    end else begin
      if (b_vld)      ptr <= nxt(b_idx);
      else if (a_vld) ptr <= nxt(a_idx);
      ram_cs_a  <= a_vld;
      ram_rnw_a <= a_vld & rnw[a_idx];
      ram_a_add <= a_vld ? add_v[a_idx] : '0;
      ram_a_din <= a_vld ? wd_v[a_idx] : '0;
      ram_cs_b  <= b_vld;
      ram_rnw_b <= b_vld & rnw[b_idx];
      ram_b_add <= b_vld ? add_v[b_idx] : '0;
      ram_b_din <= b_vld ? wd_v[b_idx] : '0;
      tag_a1    <= '{vld: a_vld, rd: a_vld & rnw[a_idx], own: a_idx};
      tag_b1    <= '{vld: b_vld, rd: b_vld & rnw[b_idx], own: b_idx};
      tag_a2    <= tag_a1;
      tag_b2    <= tag_b1;
      rd_valid  <= rv_nxt;
      for (int i = 0; i < n_req; i++) hold[i] <= slot[i];
    end
  end
endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Bench for tdp_ram_arbiter: a behavioural RAM device, a reference model of grants,
// shadow memory and read-return timing, directed cases followed by a random phase.
module tb_tdp_ram_arbiter;
  localparam int N = 4, DW = 48, AW = 4;

  typedef struct packed { logic cs; logic rnw; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;

  logic clk = 1'b0;
  logic rst, mem_clr;
  logic [N-1:0] req, rnw, gnt, rd_valid;
  logic [N*AW-1:0] add;
  logic [N*DW-1:0] wdata, rd_data;
  logic ram_cs_a, ram_cs_b, ram_rnw_a, ram_rnw_b;
  logic [AW-1:0] ram_a_add, ram_b_add;
  logic [DW-1:0] ram_a_din, ram_b_din, ram_a_dout, ram_b_dout;
  logic [AW-1:0] q_add [N];
  logic [DW-1:0] q_wd  [N];
  logic [DW-1:0] mem [1<<AW];

  // reference model state
  logic [DW-1:0] shadow [1<<AW];
  logic [N-1:0]  ev [4];
  logic [DW-1:0] ed [4][N];
  logic [DW-1:0] exp_hold [N];
  cmd_t pa, pb;
  int ptr_m, cyc, total, bad;
  int waitc [N];
  logic [N-1:0] last_gnt;

  always #5 clk = ~clk;

  always_comb begin
    add   = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      add[i*AW +: AW]   = q_add[i];
      wdata[i*DW +: DW] = q_wd[i];
    end
  end

  // RAM device: registered read returning old data on a write cycle
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < (1<<AW); k++) mem[k] <= '0;
      ram_a_dout <= '0;
      ram_b_dout <= '0;
    end else begin
      if (ram_cs_a) begin
        ram_a_dout <= mem[ram_a_add];
        if (!ram_rnw_a) mem[ram_a_add] <= ram_a_din;
      end
      if (ram_cs_b) begin
        ram_b_dout <= mem[ram_b_add];
        if (!ram_rnw_b) mem[ram_b_add] <= ram_b_din;
      end
    end
  end

  tdp_ram_arbiter #(.n_req(N), .data_wd(DW), .add_wd(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .add(add), .wdata(wdata),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_cs_a(ram_cs_a), .ram_cs_b(ram_cs_b), .ram_rnw_a(ram_rnw_a), .ram_rnw_b(ram_rnw_b),
    .ram_a_add(ram_a_add), .ram_b_add(ram_b_add), .ram_a_din(ram_a_din), .ram_b_din(ram_b_din),
    .ram_a_dout(ram_a_dout), .ram_b_dout(ram_b_dout)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic setr(input int i, input logic rd, input int a, input logic [DW-1:0] d);
    req[i]   = 1'b1;
    rnw[i]   = rd;
    q_add[i] = AW'(a);
    q_wd[i]  = d;
  endtask

  task automatic step();
    int q[$];
    int ga, gb, s;
    logic [N-1:0] eg;
    logic [N*DW-1:0] eh;
    cmd_t ca, cb;
    @(negedge clk);
    ga = -1; gb = -1; eg = '0; eh = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) if (req[(ptr_m + k) % N]) q.push_back((ptr_m + k) % N);
      if (q.size() > 0) ga = q[0];
      for (int k = 1; k < q.size() && gb < 0; k++)
        if (q_add[q[k]] != q_add[ga] || (rnw[q[k]] && rnw[ga])) gb = q[k];
    end
    if (ga >= 0) eg[ga] = 1'b1;
    if (gb >= 0) eg[gb] = 1'b1;
    s = cyc % 4;
    for (int i = 0; i < N; i++) begin
      if (ev[s][i]) exp_hold[i] = ed[s][i];
      eh[i*DW +: DW] = exp_hold[i];
    end
    chk("gnt", gnt, eg);
    chk("rd_valid", rd_valid, ev[s]);
    chk("rd_data", rd_data, eh);
    chk("cmd_a", {ram_cs_a, ram_rnw_a, ram_a_add, ram_a_din}, pa);
    chk("cmd_b", {ram_cs_b, ram_rnw_b, ram_b_add, ram_b_din}, pb);
    for (int i = 0; i < N; i++) begin
      if (req[i] && !rst) begin
        waitc[i]++;
        if (gnt[i]) begin
          chk("fair_wait", waitc[i] <= N, 1'b1);
          waitc[i] = 0;
        end
      end else waitc[i] = 0;
    end
    ev[s] = '0;
    if (rst) begin
      ptr_m = 0;
      for (int k = 0; k < 4; k++) ev[k] = '0;
      pa = '0;
      pb = '0;
      for (int i = 0; i < N; i++) exp_hold[i] = '0;
    end else begin
      ca = '0;
      cb = '0;
      if (ga >= 0) begin
        ca = '{1'b1, rnw[ga], q_add[ga], q_wd[ga]};
        ptr_m = (ga + 1) % N;
        if (rnw[ga]) begin ev[(cyc+2)%4][ga] = 1'b1; ed[(cyc+2)%4][ga] = shadow[q_add[ga]]; end
      end
      if (gb >= 0) begin
        cb = '{1'b1, rnw[gb], q_add[gb], q_wd[gb]};
        ptr_m = (gb + 1) % N;
        if (rnw[gb]) begin ev[(cyc+2)%4][gb] = 1'b1; ed[(cyc+2)%4][gb] = shadow[q_add[gb]]; end
      end
      if (ga >= 0 && !rnw[ga]) shadow[q_add[ga]] = q_wd[ga];
      if (gb >= 0 && !rnw[gb]) shadow[q_add[gb]] = q_wd[gb];
      pa = ca;
      pb = cb;
    end
    last_gnt = eg;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; ptr_m = 0; pa = '0; pb = '0; last_gnt = '0;
    for (int k = 0; k < (1<<AW); k++) shadow[k] = '0;
    for (int k = 0; k < 4; k++) ev[k] = '0;
    for (int i = 0; i < N; i++) begin exp_hold[i] = '0; waitc[i] = 0; q_add[i] = '0; q_wd[i] = '0; end
    rst = 1'b1; mem_clr = 1'b1; req = '0; rnw = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;

    // reset state with requests pending: grants suppressed
    for (int i = 0; i < N; i++) setr(i, 1'b1, i, 0);
    step();
    rst = 1'b0; req = '0;
    step();

    // write then read the same address from one requester
    setr(0, 1'b0, 3, 48'hA5A5); step();
    setr(0, 1'b1, 3, 0);        step();
    req = '0; repeat (3) step();

    // four held reads from ptr=0: pairs {0,1},{2,3}
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) setr(i, 1'b1, i + 8, 0);
    repeat (8) step();
    req = '0; repeat (2) step();

    // two writes to one address: second waits a cycle, then read back
    setr(1, 1'b0, 5, 48'h1111_2222_3333); setr(2, 1'b0, 5, 48'h4444_5555_6666); step();
    req[1] = 1'b0; step();
    req = '0; setr(0, 1'b1, 5, 0); step();
    req = '0; repeat (3) step();

    // read/read to the same address granted together
    setr(0, 1'b0, 7, 48'h7777_0000_7777); step();
    req = '0; setr(0, 1'b1, 7, 0); setr(3, 1'b1, 7, 0); step();
    req = '0; repeat (3) step();

    // reset right after read grants drops them; ptr returns to 0
    setr(0, 1'b1, 3, 0); setr(1, 1'b1, 5, 0); step();
    rst = 1'b1; step();
    rst = 1'b0; req = '0; repeat (2) step();
    for (int i = 0; i < N; i++) setr(i, 1'b1, i, 0);
    step();
    req = '0; repeat (3) step();

    // random traffic: requester 0 always busy, others random, small address space
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_gnt[i]) begin
          if (i == 0 || $urandom_range(0, 2) != 0)
            setr(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 {16'($urandom), $urandom});
          else req[i] = 1'b0;
        end
      end
      step();
    end
    req = '0; repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
